uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first, line idle high. Paired with `uart_tx`: it takes the external RX pin, synchronises it, and samples each bit at its midpoint. Each byte is delivered as a one-cycle `rx_valid` strobe with a held `rx_data`. It sits between the board RX pin and the command/packet logic, which consumes `rx_data` on `rx_valid`.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync2.sv | 29 ++
 rtl/uart_rx.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by uart_rx and uart_tx.
// Holds the state encoding, the bit-timing derivation and the counter width.
package uart_pkg;

  // Width of the per-bit cycle counter; BIT_TIME-1 must fit in it.
  localparam int CNT_W = 13;

  // Receiver state encoding; encodings 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_rx_state_e;

  // Clock cycles per bit on the line; the result must be at least 4.
  function automatic int calc_bit_time(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Clock cycles from the start edge to the middle of the start bit.
  function automatic int calc_half_bit(input int bit_time);
    return bit_time / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so that idle-high lines do not glitch low
// while reset is released.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture the asynchronous input, then let the first stage settle for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, idle-high line.
// Each bit is sampled at its midpoint. Good bytes come out as a one-cycle
// rx_valid strobe, and rx_data holds that byte until the next good frame.
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames and report
// even-parity mismatches on parity_err. Without it, parity_err is tied low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int BIT_TIME = calc_bit_time(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT = calc_half_bit(BIT_TIME);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TIME - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             w_rx_s;
  uart_rx_state_e   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_rx_busy;
  logic             r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic             r_par;
  logic             r_par_bad;
  logic             r_parity_err;
`endif

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  // Frame FSM: it times the bit midpoints, shifts in the data and drives all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= CNT_ZERO;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_rx_busy    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      // The strobes default low so that each one lasts a single cycle.
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          r_cnt <= CNT_ZERO;
          if (!w_rx_s) begin
            r_state   <= ST_START;
            r_rx_busy <= 1'b1;
          end else begin
            r_state   <= ST_IDLE;
            r_rx_busy <= 1'b0;
          end
        end

        ST_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt     <= CNT_ZERO;
            r_bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
            r_par     <= 1'b0;
            r_par_bad <= 1'b0;
`endif
            if (w_rx_s) begin
              // The line is high again at mid-start: treat it as a glitch.
              r_state   <= ST_IDLE;
              r_rx_busy <= 1'b0;
            end else begin
              r_state   <= ST_DATA;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= CNT_ZERO;
            r_shift <= {w_rx_s, r_shift[7:1]};
`ifdef UART_RX_PARITY_EN
            r_par   <= r_par ^ w_rx_s;
`endif
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt     <= CNT_ZERO;
            r_par_bad <= r_par ^ w_rx_s;
            r_state   <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
`endif

        ST_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= CNT_ZERO;
            if (w_rx_s) begin
              r_rx_data    <= r_shift;
              r_rx_valid   <= 1'b1;
              r_rx_busy    <= 1'b0;
              r_state      <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= r_par_bad;
`endif
            end else begin
              // A low stop bit may be a break, so wait for the line to go high before re-arming.
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_WAIT_HIGH: begin
          r_cnt <= CNT_ZERO;
          if (w_rx_s) begin
            r_state   <= ST_IDLE;
            r_rx_busy <= 1'b0;
          end else begin
            r_state   <= ST_WAIT_HIGH;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= CNT_ZERO;
          r_bit_idx <= 3'd0;
          r_rx_busy <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_busy   = r_rx_busy;
  assign frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at a reduced bit time of 16 clocks.
// A task-level transmitter drives frames. Expected bytes, event counts and
// strobe timing come from the frame rules, not from the receiver's internals.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = 16;
  localparam int HALF     = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PRE_STOP = 10;
`else
  localparam int PRE_STOP = 9;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] got_q[$];
  int fe_cnt = 0;
  int pe_cnt = 0;
  int pe_with_valid = 0;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_busy(rx_busy), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Record every strobe on the falling edge, away from the edge where the outputs change.
  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (parity_err) begin
      pe_cnt <= pe_cnt + 1;
      if (rx_valid) pe_with_valid <= pe_with_valid + 1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v, input int cycles);
    rx = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par, input logic stop_v, input int stop_cycles);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par, BIT);
`else
    if (bad_par) drive_bit(1'b1, 0);
`endif
    drive_bit(stop_v, stop_cycles);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    reset = 1'b0;
    drive_bit(1'b1, 2 * BIT);
  endtask

  task automatic test_single();
    int busy_n = -1;
    int valid_n = -1;
    logic busy_at_valid = 1'b1;
    logic [7:0] g;
    got_q.delete();
    fork
      send_byte(8'h55, 1'b0, 1'b1, BIT);
      begin
        for (int n = 1; n <= 400 && valid_n < 0; n++) begin
          @(posedge clk); #1;
          if (rx_busy && busy_n < 0) busy_n = n;
          if (rx_valid) begin valid_n = n; busy_at_valid = rx_busy; end
        end
      end
    join
    drive_bit(1'b1, 4);
    n_cmp++; if (valid_n != 3 + HALF + PRE_STOP * BIT) begin n_err++; $display("FAIL single_latency: got %0d want %0d", valid_n, 3 + HALF + PRE_STOP * BIT); end
    n_cmp++; if (busy_n != 3) begin n_err++; $display("FAIL single_busy_rise: got %0d want 3", busy_n); end
    n_cmp++; if (busy_at_valid !== 1'b0) begin n_err++; $display("FAIL single_busy_drop: got %b want 0", busy_at_valid); end
    n_cmp++; if (got_q.size() != 1) begin n_err++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
    n_cmp++; if (g !== 8'h55) begin n_err++; $display("FAIL single_data: got %h want 55", g); end
    n_cmp++; if (rx_data !== 8'h55) begin n_err++; $display("FAIL single_hold: got %h want 55", rx_data); end
    n_cmp++; if (fe_cnt != 0) begin n_err++; $display("FAIL single_ferr: got %0d want 0", fe_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    got_q.delete();
    exp_q.push_back(8'hA3); exp_q.push_back(8'h0F);
    send_byte(8'hA3, 1'b0, 1'b1, BIT);
    send_byte(8'h0F, 1'b0, 1'b1, BIT);
    drive_bit(1'b1, BIT);
    n_cmp++; if (got_q.size() != 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < 2 && got_q.size() > 0; i++) begin
      logic [7:0] g = got_q.pop_front();
      n_cmp++; if (g !== exp_q[i]) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", i, g, exp_q[i]); end
    end
    n_cmp++; if (fe_cnt != 0) begin n_err++; $display("FAIL b2b_ferr: got %0d want 0", fe_cnt); end
  endtask

  task automatic test_glitch();
    logic busy_seen = 1'b0;
    int fe0 = fe_cnt;
    got_q.delete();
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) rx = 1'b1;
      @(posedge clk); #1;
      if (rx_busy) busy_seen = 1'b1;
    end
    n_cmp++; if (busy_seen !== 1'b1) begin n_err++; $display("FAIL glitch_busy_seen: got %b want 1", busy_seen); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_end: got %b want 0", rx_busy); end
    n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL glitch_valid: got %0d want 0", got_q.size()); end
    n_cmp++; if (fe_cnt != fe0) begin n_err++; $display("FAIL glitch_ferr: got %0d want %0d", fe_cnt, fe0); end
  endtask

  task automatic test_frame_err();
    int fe0 = fe_cnt;
    logic [7:0] g;
    got_q.delete();
    send_byte(8'h3C, 1'b0, 1'b0, 2 * BIT);
    drive_bit(1'b1, BIT);
    n_cmp++; if (fe_cnt != fe0 + 1) begin n_err++; $display("FAIL ferr_pulse: got %0d want %0d", fe_cnt, fe0 + 1); end
    n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL ferr_novalid: got %0d want 0", got_q.size()); end
    n_cmp++; if (rx_data !== 8'h0F) begin n_err++; $display("FAIL ferr_data_held: got %h want 0f", rx_data); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy: got %b want 0", rx_busy); end
    send_byte(8'h81, 1'b0, 1'b1, BIT);
    drive_bit(1'b1, 4);
    g = (got_q.size() == 1) ? got_q.pop_front() : 8'hxx;
    n_cmp++; if (g !== 8'h81) begin n_err++; $display("FAIL ferr_recover: got %h want 81", g); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'hE7;
    logic [7:0] g;
    int fe0 = fe_cnt;
    got_q.delete();
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BIT);
    drive_bit(d[4], HALF);
    reset = 1'b1; rx = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", rx_busy); end
    n_cmp++; if (rx_valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
      n_err++; $display("FAIL rstmid_strobes: got %b%b%b want 000", rx_valid, frame_err, parity_err);
    end
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    drive_bit(1'b1, 2 * BIT);
    n_cmp++; if (got_q.size() != 0 || fe_cnt != fe0) begin n_err++; $display("FAIL rstmid_no_strobe: got %0d/%0d want 0/%0d", got_q.size(), fe_cnt, fe0); end
    send_byte(d, 1'b0, 1'b1, BIT);
    drive_bit(1'b1, 4);
    g = (got_q.size() == 1) ? got_q.pop_front() : 8'hxx;
    n_cmp++; if (g !== 8'hE7) begin n_err++; $display("FAIL rstmid_next: got %h want e7", g); end
  endtask

  task automatic test_loopback_random();
    logic [7:0] vals[256];
    logic [7:0] exp_q[$];
    int fe0 = fe_cnt;
    int pe0 = pe_cnt;
    got_q.delete();
    for (int i = 0; i < 256; i++) vals[i] = 8'(i);
    for (int i = 0; i < 255; i++) begin
      int j = $urandom_range(255, i);
      logic [7:0] t = vals[i];
      vals[i] = vals[j]; vals[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      send_byte(vals[i], 1'b0, 1'b1, BIT);
      exp_q.push_back(vals[i]);
      drive_bit(1'b1, $urandom_range(12, 0));
    end
    for (int i = 0; i < 4 * BIT && got_q.size() < 256; i++) begin @(posedge clk); #1; end
    n_cmp++; if (got_q.size() != 256) begin n_err++; $display("FAIL loop_count: got %0d want 256", got_q.size()); end
    for (int i = 0; i < 256 && got_q.size() > 0; i++) begin
      logic [7:0] g = got_q.pop_front();
      n_cmp++; if (g !== exp_q[i]) begin n_err++; $display("FAIL loop_data%0d: got %h want %h", i, g, exp_q[i]); end
    end
    n_cmp++; if (fe_cnt != fe0 || pe_cnt != pe0) begin n_err++; $display("FAIL loop_errs: got fe %0d pe %0d want fe %0d pe %0d", fe_cnt, pe_cnt, fe0, pe0); end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int pe0 = pe_cnt;
    int pv0 = pe_with_valid;
    logic [7:0] g;
    got_q.delete();
    send_byte(8'h5A, 1'b1, 1'b1, BIT);
    drive_bit(1'b1, 4);
    n_cmp++; if (pe_cnt != pe0 + 1) begin n_err++; $display("FAIL parity_pulse: got %0d want %0d", pe_cnt, pe0 + 1); end
    n_cmp++; if (pe_with_valid != pv0 + 1) begin n_err++; $display("FAIL parity_with_valid: got %0d want %0d", pe_with_valid, pv0 + 1); end
    g = (got_q.size() == 1) ? got_q.pop_front() : 8'hxx;
    n_cmp++; if (g !== 8'h5A) begin n_err++; $display("FAIL parity_data: got %h want 5a", g); end
`else
    n_cmp++; if (pe_cnt != 0) begin n_err++; $display("FAIL parity_tied: got %0d want 0", pe_cnt); end
    n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL parity_level: got %b want 0", parity_err); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_loopback_random();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
